maze_path_checker: RTL

MAZE_PATH_CHECKER -- requirements
Module: maze_path_checker

---
 rtl/maze_path_checker.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/maze_path_checker.sv
// Maze path checker: once done rises, raster-scans the path one cell per clock and reports
// wall, start/stop and isolation errors together with path length and time spent waiting.
module maze_path_checker #(
    parameter int unsigned SIZE = 9,
    parameter int unsigned N    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [SIZE-1:0][SIZE-1:0] maze,
    input  logic [SIZE-1:0][SIZE-1:0] path,
    input  logic                      done,
    output logic                      result_valid,
    output logic                      pass,
    output logic                      err_wall,
    output logic                      err_start,
    output logic                      err_stop,
    output logic                      err_isolated,
    output logic [N-1:0]              err_x,
    output logic [N-1:0]              err_y,
    output logic [7:0]                path_len,
    output logic [15:0]               cycles
);

    typedef enum logic [1:0] {StWait, StScan, StFinal, StReport} state_e;

    localparam logic [N-1:0] Last = N'(SIZE - 1);

    state_e       state_q, state_d;
    logic [N-1:0] row_q, row_d, col_q, col_d;
    logic         start_seen_q, start_seen_d, stop_seen_q, stop_seen_d;
    logic         valid_q, valid_d, pass_q, pass_d;
    logic         wall_q, wall_d, start_q, start_d, stop_q, stop_d, iso_q, iso_d;
    logic [N-1:0] ex_q, ex_d, ey_q, ey_d;
    logic [7:0]   len_q, len_d;
    logic [15:0]  cyc_q, cyc_d;
    logic         cur_path, cur_wall, has_nb;

    // Neighbour lookup for the cell under the scan pointer; off-grid neighbours read as 0.
    always_comb begin
        cur_path = path[row_q][col_q];
        cur_wall = maze[row_q][col_q];
        has_nb   = 1'b0;
        if (row_q != '0)   has_nb = has_nb | path[row_q - N'(1)][col_q];
        if (row_q != Last) has_nb = has_nb | path[row_q + N'(1)][col_q];
        if (col_q != '0)   has_nb = has_nb | path[row_q][col_q - N'(1)];
        if (col_q != Last) has_nb = has_nb | path[row_q][col_q + N'(1)];
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        start_seen_d = start_seen_q;
        stop_seen_d  = stop_seen_q;
        valid_d      = valid_q;
        pass_d       = pass_q;
        wall_d       = wall_q;
        start_d      = start_q;
        stop_d       = stop_q;
        iso_d        = iso_q;
        ex_d         = ex_q;
        ey_d         = ey_q;
        len_d        = len_q;
        cyc_d        = cyc_q;

        unique case (state_q)
            StWait: begin
                if (done) begin
                    row_d        = '0;
                    col_d        = '0;
                    start_seen_d = 1'b0;
                    stop_seen_d  = 1'b0;
                    wall_d       = 1'b0;
                    iso_d        = 1'b0;
                    ex_d         = '0;
                    ey_d         = '0;
                    len_d        = '0;
                    state_d      = StScan;
                end else if (cyc_q != 16'hFFFF) begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            StScan: begin
                if (cur_path) begin
                    if (len_q != 8'hFF) len_d = len_q + 8'd1;
                    if (row_q == '0)    start_seen_d = 1'b1;
                    if (row_q == Last)  stop_seen_d  = 1'b1;
                    if (cur_wall)       wall_d       = 1'b1;
                    if (!has_nb)        iso_d        = 1'b1;
                    // Only the first offending cell in raster order is reported.
                    if ((cur_wall || !has_nb) && !(wall_q || iso_q)) begin
                        ex_d = col_q;
                        ey_d = row_q;
                    end
                end
                if (col_q == Last) begin
                    col_d = '0;
                    if (row_q == Last) state_d = StFinal;
                    else               row_d   = row_q + N'(1);
                end else begin
                    col_d = col_q + N'(1);
                end
            end
            StFinal: begin
                start_d = !start_seen_q;
                stop_d  = !stop_seen_q;
                pass_d  = !(wall_q || iso_q || !start_seen_q || !stop_seen_q);
                valid_d = 1'b1;
                state_d = StReport;
            end
            StReport: begin
                if (!done) begin
                    valid_d = 1'b0;
                    pass_d  = 1'b0;
                    wall_d  = 1'b0;
                    start_d = 1'b0;
                    stop_d  = 1'b0;
                    iso_d   = 1'b0;
                    ex_d    = '0;
                    ey_d    = '0;
                    len_d   = '0;
                    cyc_d   = '0;
                    state_d = StWait;
                end
            end
            default: state_d = StWait;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StWait;
            row_q        <= '0;
            col_q        <= '0;
            start_seen_q <= 1'b0;
            stop_seen_q  <= 1'b0;
            valid_q      <= 1'b0;
            pass_q       <= 1'b0;
            wall_q       <= 1'b0;
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
            iso_q        <= 1'b0;
            ex_q         <= '0;
            ey_q         <= '0;
            len_q        <= '0;
            cyc_q        <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            start_seen_q <= start_seen_d;
            stop_seen_q  <= stop_seen_d;
            valid_q      <= valid_d;
            pass_q       <= pass_d;
            wall_q       <= wall_d;
            start_q      <= start_d;
            stop_q       <= stop_d;
            iso_q        <= iso_d;
            ex_q         <= ex_d;
            ey_q         <= ey_d;
            len_q        <= len_d;
            cyc_q        <= cyc_d;
        end
    end

    assign result_valid = valid_q;
    assign pass         = pass_q;
    assign err_wall     = wall_q;
    assign err_start    = start_q;
    assign err_stop     = stop_q;
    assign err_isolated = iso_q;
    assign err_x        = ex_q;
    assign err_y        = ey_q;
    assign path_len     = len_q;
    assign cycles       = cyc_q;

endmodule
